// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - 640x480@60 timing generator driven by a pixel strobe
// The pixel clock is never generated; all state advances on a one-clk pix_en strobe.
module vga_timing_ctrl #(
  parameter int   CLK_DIV     = 4,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_FP0    = 10'(H_ACTIVE);
  localparam logic [9:0] X_SYNC0  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] X_BP0    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] Y_VS0    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] Y_VS1    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} hstate_t;

  logic [DIV_W-1:0] div;
  hstate_t          hstate;
  logic             en_seen;
  logic             tick;
  logic             x_wrap;
  logic             y_wrap;
  logic [9:0]       x_next;

  // Counters move on the same edge that raises pix_en, so pix_en is coincident with the new x/y.
  assign tick   = en && (div == DIV_LAST);
  assign x_wrap = (x == X_LAST);
  assign y_wrap = (y == Y_LAST);
  assign x_next = x_wrap ? 10'd0 : x + 10'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      x           <= '0;
      y           <= '0;
      hstate      <= HS_ACT;
      en_seen     <= 1'b0;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= tick;
      frame_start <= tick && x_wrap && y_wrap;
      if (en) begin
        div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end
      if (tick) begin
        en_seen <= 1'b1;
        x       <= x_next;
        if (x_wrap) begin
          y <= y_wrap ? 10'd0 : y + 10'd1;
        end
        case (hstate)
          HS_ACT:  if (x_next == X_FP0)   hstate <= HS_FP;
          HS_FP:   if (x_next == X_SYNC0) hstate <= HS_SYNC;
          HS_SYNC: if (x_next == X_BP0)   hstate <= HS_BP;
          HS_BP:   if (x_wrap)            hstate <= HS_ACT;
          default:                        hstate <= HS_ACT;
        endcase
      end
    end
  end

  assign hsync    = (hstate == HS_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync    = (y >= Y_VS0 && y <= Y_VS1) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign video_on = en_seen && (hstate == HS_ACT) && (y < Y_VIS);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed bench for vga_timing_ctrl
// DUT a uses default timing; DUT b is a tiny 15x13 frame with CLK_DIV=2, active-high syncs.
module tb_vga_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n_a, en_a, rst_n_b, en_b;
  logic       pix_en_a, hsync_a, vsync_a, video_on_a, frame_start_a;
  logic       pix_en_b, hsync_b, vsync_b, video_on_b, frame_start_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl dut_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .pix_en(pix_en_a), .hsync(hsync_a),
    .vsync(vsync_a), .video_on(video_on_a), .x(x_a), .y(y_a), .frame_start(frame_start_a)
  );

  vga_timing_ctrl #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .pix_en(pix_en_b), .hsync(hsync_b),
    .vsync(vsync_b), .video_on(video_on_b), .x(x_b), .y(y_b), .frame_start(frame_start_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_pix_a(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!pix_en_a && edges < 64);
    if (!pix_en_a) check("a_pix_timeout", pix_en_a, 1);
  endtask

  task automatic wait_pix_b(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!pix_en_b && edges < 64);
    if (!pix_en_b) check("b_pix_timeout", pix_en_b, 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_x"}, x_a, 0);
    check({tag, "_y"}, y_a, 0);
    check({tag, "_hsync"}, hsync_a, 1);
    check({tag, "_vsync"}, vsync_a, 1);
    check({tag, "_pix_en"}, pix_en_a, 0);
    check({tag, "_video_on"}, video_on_a, 0);
    check({tag, "_frame_start"}, frame_start_a, 0);
  endtask

  initial begin
    int e;
    int hs_cnt, hs_first, vid_cnt, vid_last, prev_x, prev_y;
    int bad_pix, bad_x;
    int vs_cnt, vid_late, hs_bad, fs_cnt, fs_first, fs_bad, bad_sp;

    rst_n_a = 1'b0; en_a = 1'b1;
    rst_n_b = 1'b0; en_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("a_rst");

    // release and first-strobe latency
    rst_n_a = 1'b1;
    wait_pix_a(e);
    check("a_first_pix_edges", e, 4);
    check("a_first_x", x_a, 1);
    check("a_first_video_on", video_on_a, 1);
    wait_pix_a(e);
    check("a_pix_spacing", e, 4);

    // advance to the start of line 1, checking the 799 -> 0 wrap
    prev_x = x_a;
    for (int k = 0; k < 900 && !(x_a == 0 && y_a == 1); k++) begin
      prev_x = x_a;
      wait_pix_a(e);
    end
    check("a_wrap_prev_x", prev_x, 799);
    check("a_wrap_y", y_a, 1);
    check("a_wrap_x", x_a, 0);

    // one full line on y = 1
    hs_cnt = 0; hs_first = -1; vid_cnt = 0; vid_last = -1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) wait_pix_a(e);
      if (hsync_a == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = x_a;
      end
      if (video_on_a) begin
        vid_cnt++;
        vid_last = x_a;
      end
    end
    check("a_hsync_len", hs_cnt, 96);
    check("a_hsync_first_x", hs_first, 656);
    check("a_video_cnt", vid_cnt, 640);
    check("a_video_last_x", vid_last, 639);
    wait_pix_a(e);
    check("a_line2_x", x_a, 0);
    check("a_line2_y", y_a, 2);

    // pause mid-period at x = 300
    for (int k = 0; k < 400 && x_a != 300; k++) wait_pix_a(e);
    check("a_at_300", x_a, 300);
    repeat (2) @(posedge clk);
    #1;
    en_a = 1'b0;
    bad_pix = 0; bad_x = 0;
    for (int k = 0; k < 37; k++) begin
      @(posedge clk); #1;
      if (pix_en_a) bad_pix++;
      if (x_a != 300 || y_a != 2 || hsync_a != 1'b1) bad_x++;
    end
    check("a_pause_pix_en", bad_pix, 0);
    check("a_pause_hold", bad_x, 0);
    en_a = 1'b1;
    wait_pix_a(e);
    check("a_resume_edges", e, 2);
    check("a_resume_x", x_a, 301);

    // asynchronous reset mid-line while hsync is active
    for (int k = 0; k < 800 && x_a != 700; k++) wait_pix_a(e);
    check("a_at_700_hsync", hsync_a, 0);
    #3;
    rst_n_a = 1'b0;
    #1;
    check_reset_a("a_async_rst");
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    wait_pix_a(e);
    check("a_restart_edges", e, 4);
    check("a_restart_x", x_a, 1);

    // small DUT: two full frames
    rst_n_b = 1'b1;
    vs_cnt = 0; hs_cnt = 0; vid_cnt = 0; vid_late = 0; hs_bad = 0;
    fs_cnt = 0; fs_first = -1; fs_bad = 0; bad_sp = 0;
    prev_x = 0; prev_y = 0;
    for (int i = 1; i <= 390; i++) begin
      wait_pix_b(e);
      if (i == 1) check("b_first_pix_edges", e, 2);
      else if (e != 2) bad_sp++;
      if (hsync_b) begin
        hs_cnt++;
        if (x_b < 10 || x_b > 12) hs_bad++;
      end
      if (vsync_b) vs_cnt++;
      if (video_on_b) begin
        vid_cnt++;
        if (y_b >= 6) vid_late++;
      end
      if (frame_start_b) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        if (prev_x != 14 || prev_y != 12 || x_b != 0 || y_b != 0) fs_bad++;
      end
      prev_x = x_b;
      prev_y = y_b;
    end
    check("b_pix_spacing", bad_sp, 0);
    check("b_hsync_cnt", hs_cnt, 78);
    check("b_hsync_window", hs_bad, 0);
    check("b_vsync_cnt", vs_cnt, 60);
    check("b_video_cnt", vid_cnt, 96);
    check("b_video_late", vid_late, 0);
    check("b_frame_start_cnt", fs_cnt, 2);
    check("b_frame_start_first", fs_first, 195);
    check("b_frame_start_pos", fs_bad, 0);

    // small DUT: async reset while both syncs are active-high
    for (int k = 0; k < 300 && !(x_b == 11 && y_b == 8); k++) wait_pix_b(e);
    check("b_sync_h", hsync_b, 1);
    check("b_sync_v", vsync_b, 1);
    #3;
    rst_n_b = 1'b0;
    #1;
    check("b_rst_hsync", hsync_b, 0);
    check("b_rst_vsync", vsync_b, 0);
    check("b_rst_x", x_b, 0);
    check("b_rst_y", y_b, 0);
    check("b_rst_pix_en", pix_en_b, 0);
    check("b_rst_video_on", video_on_b, 0);
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    wait_pix_b(e);
    check("b_restart_edges", e, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the 640x480@60 Hz pixel datapath from the 100 MHz system clock.
- Derives a one-cycle pixel enable every CLK_DIV system clocks, giving a 25 MHz pixel rate, in place of a divided clock.
- Runs horizontal and vertical counters and a horizontal phase state machine on that enable.
- Outputs sync, blanking and pixel coordinates to the pixel generator and the VGA connector.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=2)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- SYNC_ACTIVE, 0, asserted level of hsync and vsync

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low pauses the timing
- pix_en  out  1  one-clk pixel strobe
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high for a visible pixel
- x  out  10  horizontal pixel counter
- y  out  10  vertical line counter
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-frame):
  - div counter = 0, x = 0, y = 0, hstate = H_ACT.
  - pix_en = 0, video_on = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_ACTIVE.
- Divider:
  - div counts 0..CLK_DIV-1 on each clk while en = 1, then wraps to 0.
  - pix_en is registered and is high for the one clk after div = CLK_DIV-1.
  - Pixel period is exactly CLK_DIV clks.
  - With en = 0: div, x, y and hstate hold, pix_en = 0, and all other outputs hold their values.
  - Re-asserting en resumes from the held div value, so there is no extra or short pixel.
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800. V_TOTAL = 525.
- Counter update, on the clk where pix_en = 1 (counters registered; all outputs are decoded from them, with no extra latency):
  - x increments; at x = H_TOTAL-1 it wraps to 0.
  - y increments only on an x wrap; at y = V_TOTAL-1 it wraps to 0.
  - Both counters are 10-bit unsigned. Parameters must keep totals ≤ 1024.
- Horizontal FSM (advances only with pix_en); transition when x reaches the first pixel of the next phase:
  - H_ACT, x 0..639 → H_FP at x = 640.
  - H_FP, 640..655 → H_SYNC at x = 656.
  - H_SYNC, 656..751 → H_BP at x = 752.
  - H_BP, 752..799 → H_ACT on wrap to 0.
- Output decode:
  - hsync = SYNC_ACTIVE iff hstate = H_SYNC.
  - vsync = SYNC_ACTIVE iff y is in 490..491, i.e. V_ACTIVE+V_FP to V_ACTIVE+V_FP+V_SYNC-1.
  - video_on = en_seen & (hstate = H_ACT) & (y < V_ACTIVE).
  - en_seen is set on the first pix_en after reset and cleared only by reset, so video_on is 0 right after reset.
  - frame_start is high for the one clk on which x and y both wrap to 0, coincident with that pix_en. The first frame after reset produces no frame_start.
- Simultaneous events:
  - x wrap and y wrap occur in the same clk; y wrap takes priority and y goes to 0, never 525.
  - en falling in the same clk as a pix_en: that update completes, then the block pauses.

Test Plan:
- Reset: hold rst_n = 0 with en = 1 → x = y = 0, hsync = vsync = 1, pix_en = video_on = frame_start = 0. Release → first pix_en on the 4th clk, then every 4 clks.
- Line timing: run 800 pix_en → hsync low for exactly 96 strobes starting at x = 656. video_on high for x 0..639 on y = 0. x wraps 799 → 0 and y 0 → 1.
- Frame timing: run 420000 pix_en → vsync low for y = 490..491, i.e. 1600 strobes. video_on never high for y ≥ 480. frame_start fires once, at y 524 → 0 and x 799 → 0.
- Pause: drop en for 37 clks at x = 300 → x, y, hsync and div hold and pix_en stays 0. Re-enable → next pix_en spacing accounts for the held div, and x continues 300 → 301.
- Mid-frame reset: assert rst_n = 0 asynchronously (between clk edges) at y = 250, x = 700 → all outputs go to their reset values without a clk edge. Restart timing is identical to the first scenario.
- Parameter sweep: CLK_DIV = 2, SYNC_ACTIVE = 1 → pix_en every 2 clks, and hsync/vsync are high during their sync windows.
